// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: allocation, resolve and PD_Stage update bundle for branch_resolve_unit.
// master = dispatch/EX/PD_Stage side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32,
    parameter int PHT_ADDRESS = 9,
    parameter int GHR_SIZE = 9,
    parameter int RAS_ADDRESS = 3,
    parameter int TAG_W = 3
);
    logic alloc_valid, alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [XLEN-1:0] alloc_pc, alloc_pred_target;
    logic alloc_is_branch, alloc_is_call, alloc_is_ret, alloc_pred_taken, alloc_btb_hit;
    logic [PHT_ADDRESS-1:0] alloc_pht_index;
    logic [GHR_SIZE-1:0] alloc_ghr;
    logic [RAS_ADDRESS-1:0] alloc_sp_snap;
    logic [2*XLEN-1:0] alloc_ras_snap;
    logic res_valid, res_taken;
    logic [TAG_W-1:0] res_tag;
    logic [XLEN-1:0] res_target;
    logic actual_taken, mispredict, restore_ghr, restore_ras;
    logic update_pht, update_btb, update_ras, ex_is_ret, ex_is_branch;
    logic [XLEN-1:0] actual_target_address, actual_return_address, ex_pc;
    logic [GHR_SIZE-1:0] ghr_snap;
    logic [PHT_ADDRESS-1:0] rb_pht_index;
    logic [RAS_ADDRESS-1:0] rb_sp_snap;
    logic [2*XLEN-1:0] rb_ras_snap;
    logic full, empty;
    logic [31:0] stat_branches, stat_mispredicts;

    modport master (
        output alloc_valid, alloc_pc, alloc_is_branch, alloc_is_call, alloc_is_ret,
               alloc_pred_taken, alloc_btb_hit, alloc_pred_target, alloc_pht_index,
               alloc_ghr, alloc_sp_snap, alloc_ras_snap, res_valid, res_tag, res_taken, res_target,
        input  alloc_ready, alloc_tag, actual_taken, mispredict, restore_ghr, restore_ras,
               update_pht, update_btb, update_ras, ex_is_ret, ex_is_branch,
               actual_target_address, actual_return_address, ex_pc, ghr_snap, rb_pht_index,
               rb_sp_snap, rb_ras_snap, full, empty, stat_branches, stat_mispredicts
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_is_branch, alloc_is_call, alloc_is_ret,
               alloc_pred_taken, alloc_btb_hit, alloc_pred_target, alloc_pht_index,
               alloc_ghr, alloc_sp_snap, alloc_ras_snap, res_valid, res_tag, res_taken, res_target,
        output alloc_ready, alloc_tag, actual_taken, mispredict, restore_ghr, restore_ras,
               update_pht, update_btb, update_ras, ex_is_ret, ex_is_branch,
               actual_target_address, actual_return_address, ex_pc, ghr_snap, rb_pht_index,
               rb_sp_snap, rb_ras_snap, full, empty, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checkpoints predicted control flow, resolves it against EX and drives PD_Stage updates.
// Define BRU_STATS_EN to get resolve/mispredict counters; otherwise the stat outputs are tied to 0.
module branch_resolve_unit #(
    parameter int XLEN = 32,
    parameter int PHT_ADDRESS = 9,
    parameter int GHR_SIZE = 9,
    parameter int RAS_ADDRESS = 3,
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input logic CLK,
    input logic reset,
    branch_resolve_unit_if.slave bus
);
    logic [DEPTH-1:0] valid, done, is_branch, is_call, is_ret, pred_taken, btb_hit;
    logic [XLEN-1:0] pc [DEPTH];
    logic [XLEN-1:0] pred_target [DEPTH];
    logic [PHT_ADDRESS-1:0] pht_index [DEPTH];
    logic [GHR_SIZE-1:0] ghr [DEPTH];
    logic [RAS_ADDRESS-1:0] sp_snap [DEPTH];
    logic [2*XLEN-1:0] ras_snap [DEPTH];
    logic [TAG_W-1:0] head, tail, span;
    logic [TAG_W:0] count;
    logic hit, fire, mis, flush_now, alloc_fire, retire;
    logic [XLEN-1:0] r_pc, r_tgt, r_ret;

    assign bus.full = count == (TAG_W+1)'(DEPTH);
    assign bus.empty = count == '0;
    assign bus.alloc_tag = tail;
    assign r_pc = pc[bus.res_tag];
    assign r_tgt = pred_target[bus.res_tag];
    assign r_ret = r_pc + XLEN'(4);
    assign hit = bus.res_valid && valid[bus.res_tag] && !done[bus.res_tag];
    assign fire = hit && !reset;
    assign mis = is_branch[bus.res_tag]
        ? (bus.res_taken != pred_taken[bus.res_tag]) || (bus.res_taken && bus.res_target != r_tgt)
        : !pred_taken[bus.res_tag] || bus.res_target != r_tgt;
    assign flush_now = hit && mis;
    assign bus.alloc_ready = !bus.full && !flush_now;
    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    assign retire = valid[head] && done[head];
    assign span = bus.res_tag - head;

    always_ff @(posedge CLK) begin
        if (alloc_fire) begin
            pc[tail] <= bus.alloc_pc;
            pred_target[tail] <= bus.alloc_pred_target;
            pht_index[tail] <= bus.alloc_pht_index;
            ghr[tail] <= bus.alloc_ghr;
            sp_snap[tail] <= bus.alloc_sp_snap;
            ras_snap[tail] <= bus.alloc_ras_snap;
            is_branch[tail] <= bus.alloc_is_branch;
            is_call[tail] <= bus.alloc_is_call;
            is_ret[tail] <= bus.alloc_is_ret;
            pred_taken[tail] <= bus.alloc_pred_taken;
            btb_hit[tail] <= bus.alloc_btb_hit;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            done <= '0;
        end else begin
            if (retire) begin
                valid[head] <= 1'b0;
                head <= head + TAG_W'(1);
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail <= tail + TAG_W'(1);
            end
            if (hit) done[bus.res_tag] <= 1'b1;
            // Age is measured from head, so anything further from head than res_tag is younger.
            if (flush_now) begin
                for (int i = 0; i < DEPTH; i++)
                    if (TAG_W'(i) - head > span) valid[i] <= 1'b0;
                tail <= bus.res_tag + TAG_W'(1);
                count <= {1'b0, span} + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
            end else begin
                count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
            end
        end
    end

    always_ff @(posedge CLK) begin
        bus.actual_taken <= fire && bus.res_taken;
        bus.mispredict <= fire && mis;
        bus.restore_ghr <= fire && mis;
        bus.restore_ras <= fire && mis;
        bus.update_pht <= fire && is_branch[bus.res_tag];
        bus.update_btb <= fire && bus.res_taken && (!btb_hit[bus.res_tag] || bus.res_target != r_tgt);
        bus.update_ras <= fire && is_call[bus.res_tag];
        bus.ex_is_ret <= fire && is_ret[bus.res_tag];
        bus.ex_is_branch <= fire && is_branch[bus.res_tag];
        bus.ex_pc <= fire ? r_pc : '0;
        bus.actual_target_address <= fire ? (bus.res_taken ? bus.res_target : r_ret) : '0;
        bus.actual_return_address <= fire ? r_ret : '0;
        bus.ghr_snap <= fire ? ghr[bus.res_tag] : '0;
        bus.rb_pht_index <= fire ? pht_index[bus.res_tag] : '0;
        bus.rb_sp_snap <= fire ? sp_snap[bus.res_tag] : '0;
        bus.rb_ras_snap <= fire ? ras_snap[bus.res_tag] : '0;
    end

`ifdef BRU_STATS_EN
    logic [31:0] n_br, n_mis;
    always_ff @(posedge CLK) begin
        if (reset) begin
            n_br <= '0;
            n_mis <= '0;
        end else begin
            n_br <= n_br + 32'(hit);
            n_mis <= n_mis + 32'(flush_now);
        end
    end
    assign bus.stat_branches = n_br;
    assign bus.stat_mispredicts = n_mis;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_mispredicts = '0;
`endif
endmodule
